// File: rtl/conv_mac_pe_if.sv
// conv_mac_pe_if: beat/result bundle for the conv_mac_pe processing element.
//   master : controller side, drives beats (in_valid/in_first/in_last/x/w),
//            receives results (odata/out_valid/sat)
//   slave  : PE side, the mirror image
// x and w carry TAPS signed lanes, lane i at [i*DATA_W +: DATA_W].
interface conv_mac_pe_if #(
    parameter int DATA_W = 16,
    parameter int TAPS   = 4,
    parameter int OUT_W  = 32
);
    logic                     in_valid;
    logic                     in_first;
    logic                     in_last;
    logic [TAPS*DATA_W-1:0]   x;
    logic [TAPS*DATA_W-1:0]   w;
    logic [OUT_W-1:0]         odata;
    logic                     out_valid;
    logic                     sat;

    modport master (
        output in_valid, in_first, in_last, x, w,
        input  odata, out_valid, sat
    );

    modport slave (
        input  in_valid, in_first, in_last, x, w,
        output odata, out_valid, sat
    );
endinterface

// File: rtl/conv_mac_pe.sv
// conv_mac_pe: multiply-accumulate processing element for conv layers.
// Each valid beat multiplies TAPS signed x/w pairs, sums them and accumulates
// across the beats of one output point (in_first .. in_last). On the last
// beat a requantised (>>> SHIFT), saturated result is emitted with a
// one-cycle out_valid pulse; sat flags a clipped result.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous, active-high reset
//   bus  - conv_mac_pe_if slave: beats in, results out
// Pipeline: input reg -> lane product -> lane sum -> accumulate/saturate.
// A beat sampled at edge N produces out_valid in the cycle after edge N+3.

// Per-lane input register plus signed multiplier register.
module conv_mac_lane #(
    parameter int DATA_W = 16
) (
    input  logic                       clk,
    input  logic signed [DATA_W-1:0]   x,
    input  logic signed [DATA_W-1:0]   w,
    output logic signed [2*DATA_W-1:0] p
);
    logic signed [DATA_W-1:0] x_q;
    logic signed [DATA_W-1:0] w_q;

    // Data path carries no reset; validity is tracked by the valid pipe.
    always_ff @(posedge clk) begin
        x_q <= x;
        w_q <= w;
        p   <= (2*DATA_W)'(x_q) * (2*DATA_W)'(w_q);
    end
endmodule

module conv_mac_pe #(
    parameter int DATA_W = 16,
    parameter int TAPS   = 4,
    parameter int ACC_W  = 40,
    parameter int OUT_W  = 32,
    parameter int SHIFT  = 0
) (
    input  logic         clk,
    input  logic         rst,
    conv_mac_pe_if.slave bus
);
    // [0] input reg, [1] product reg, [2] sum reg
    localparam int STAGES = 2;

    logic [STAGES:0]               vld_pipe;
    logic [STAGES:0]               first_pipe;
    logic [STAGES:0]               last_pipe;
    logic [TAPS-1:0][2*DATA_W-1:0] p;
    logic signed [ACC_W-1:0]       psum;
    logic signed [ACC_W-1:0]       s;
    logic signed [ACC_W-1:0]       acc;
    logic signed [ACC_W-1:0]       acc_next;
    logic signed [ACC_W-1:0]       shifted;
    logic [ACC_W-OUT_W:0]          top_bits;
    logic                          clip;
    logic [OUT_W-1:0]              clip_val;
    logic [OUT_W-1:0]              odata_q;
    logic                          sat_q;
    logic                          out_valid_q;

    for (genvar i = 0; i < TAPS; i++) begin : g_lane
        conv_mac_lane #(.DATA_W(DATA_W)) u_lane (
            .clk (clk),
            .x   (bus.x[i*DATA_W +: DATA_W]),
            .w   (bus.w[i*DATA_W +: DATA_W]),
            .p   (p[i])
        );
    end

    // Flags travel alongside the data; reset drops every beat in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe   <= '0;
            first_pipe <= '0;
            last_pipe  <= '0;
        end else begin
            vld_pipe   <= {vld_pipe[STAGES-1:0],   bus.in_valid};
            first_pipe <= {first_pipe[STAGES-1:0], bus.in_first};
            last_pipe  <= {last_pipe[STAGES-1:0],  bus.in_last};
        end
    end

    always_comb begin
        psum = '0;
        for (int i = 0; i < TAPS; i++) begin
            psum = psum + ACC_W'($signed(p[i]));
        end
    end

    always_ff @(posedge clk) begin
        s <= psum;
    end

    // The value fits OUT_W iff every bit from the OUT_W sign bit upward
    // matches; otherwise clip toward the side given by the true sign.
    always_comb begin
        acc_next = first_pipe[STAGES] ? s : acc + s;
        shifted  = acc_next >>> SHIFT;
        top_bits = shifted[ACC_W-1:OUT_W-1];
        clip     = !((&top_bits) || !(|top_bits));
        clip_val = shifted[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                    : {1'b0, {(OUT_W-1){1'b1}}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc         <= '0;
            odata_q     <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            if (vld_pipe[STAGES]) begin
                acc <= acc_next;
                if (last_pipe[STAGES]) begin
                    out_valid_q <= 1'b1;
                    sat_q       <= clip;
                    odata_q     <= clip ? clip_val : shifted[OUT_W-1:0];
                end
            end
        end
    end

    assign bus.odata     = odata_q;
    assign bus.sat       = sat_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_conv_mac_pe.sv
// tb_conv_mac_pe: scoreboard bench for conv_mac_pe. Three instances share
// identical stimulus: d0 (OUT_W=32, SHIFT=0), d1 (OUT_W=16, SHIFT=0) and
// d2 (OUT_W=32, SHIFT=4). A point-level model queues expected results with
// their due cycle; a negedge monitor pops and compares every pulse.
module tb_conv_mac_pe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    conv_mac_pe_if #(.DATA_W(16), .TAPS(4), .OUT_W(32)) if0 ();
    conv_mac_pe_if #(.DATA_W(16), .TAPS(4), .OUT_W(16)) if1 ();
    conv_mac_pe_if #(.DATA_W(16), .TAPS(4), .OUT_W(32)) if2 ();

    conv_mac_pe #(.DATA_W(16), .TAPS(4), .ACC_W(40), .OUT_W(32), .SHIFT(0))
        dut0 (.clk(clk), .rst(rst), .bus(if0));
    conv_mac_pe #(.DATA_W(16), .TAPS(4), .ACC_W(40), .OUT_W(16), .SHIFT(0))
        dut1 (.clk(clk), .rst(rst), .bus(if1));
    conv_mac_pe #(.DATA_W(16), .TAPS(4), .ACC_W(40), .OUT_W(32), .SHIFT(4))
        dut2 (.clk(clk), .rst(rst), .bus(if2));

    typedef struct {
        longint d;
        logic   s;
        int     due;
    } exp_t;

    exp_t   q0[$];
    exp_t   q1[$];
    exp_t   q2[$];
    int     n_chk  = 0;
    int     n_fail = 0;
    longint macc   = 0;
    int     shv[3] = '{0, 0, 4};
    int     owv[3] = '{32, 16, 32};

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pk(input int a, input int b, input int c, input int d);
        return {d[15:0], c[15:0], b[15:0], a[15:0]};
    endfunction

    function automatic longint bsum(input logic [63:0] xv, input logic [63:0] wv);
        longint r = 0;
        for (int i = 0; i < 4; i++)
            r += longint'($signed(xv[i*16 +: 16])) * longint'($signed(wv[i*16 +: 16]));
        return r;
    endfunction

    task automatic push_all(input int due);
        exp_t   e;
        longint t, mx, mn;
        for (int k = 0; k < 3; k++) begin
            t  = macc >>> shv[k];
            mx = (longint'(1) <<< (owv[k] - 1)) - 1;
            mn = -mx - 1;
            e.d   = (t > mx) ? mx : (t < mn) ? mn : t;
            e.s   = (t > mx) || (t < mn);
            e.due = due;
            case (k)
                0:       q0.push_back(e);
                1:       q1.push_back(e);
                default: q2.push_back(e);
            endcase
        end
    endtask

    task automatic set_in(input logic v, input logic f, input logic l,
                          input logic [63:0] xv, input logic [63:0] wv);
        if0.in_valid = v; if0.in_first = f; if0.in_last = l; if0.x = xv; if0.w = wv;
        if1.in_valid = v; if1.in_first = f; if1.in_last = l; if1.x = xv; if1.w = wv;
        if2.in_valid = v; if2.in_first = f; if2.in_last = l; if2.x = xv; if2.w = wv;
    endtask

    // Drive one cycle; valid beats update the model after the sampling edge.
    task automatic beat(input logic v, input logic f, input logic l,
                        input logic [63:0] xv, input logic [63:0] wv);
        longint s;
        set_in(v, f, l, xv, wv);
        @(posedge clk); #1;
        if (v && !rst) begin
            s    = bsum(xv, wv);
            macc = f ? s : macc + s;
            macc = (macc <<< 24) >>> 24;   // 40-bit wrap
            if (l) push_all(cyc + 3);
        end
    endtask

    task automatic idle(input int n);
        set_in(1'b0, 1'b0, 1'b0, '0, '0);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_d0_valid"}, longint'(if0.out_valid), 0);
        chk({tag, "_d0_odata"}, longint'(if0.odata), 0);
        chk({tag, "_d0_sat"},   longint'(if0.sat), 0);
        chk({tag, "_d1_valid"}, longint'(if1.out_valid), 0);
        chk({tag, "_d1_odata"}, longint'(if1.odata), 0);
        chk({tag, "_d1_sat"},   longint'(if1.sat), 0);
        chk({tag, "_d2_valid"}, longint'(if2.out_valid), 0);
        chk({tag, "_d2_odata"}, longint'(if2.odata), 0);
        chk({tag, "_d2_sat"},   longint'(if2.sat), 0);
    endtask

    task automatic mon(input int k, input logic ov, input longint od, input logic s);
        exp_t e;
        int   qn;
        if (ov !== 1'b1) return;
        qn = (k == 0) ? q0.size() : (k == 1) ? q1.size() : q2.size();
        if (qn == 0) begin
            chk($sformatf("d%0d_unexpected_pulse_queue", k), longint'(qn), 1);
            return;
        end
        case (k)
            0:       e = q0.pop_front();
            1:       e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
        chk($sformatf("d%0d_odata", k), od, e.d);
        chk($sformatf("d%0d_sat", k), longint'(s), longint'(e.s));
        chk($sformatf("d%0d_latency_cycle", k), longint'(cyc), longint'(e.due));
    endtask

    always @(negedge clk) begin
        mon(0, if0.out_valid, longint'($signed(if0.odata)), if0.sat);
        mon(1, if1.out_valid, longint'($signed(if1.odata)), if1.sat);
        mon(2, if2.out_valid, longint'($signed(if2.odata)), if2.sat);
    end

    initial begin
        // Reset state
        rst = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b0;
        macc = 0;

        // Single-beat point: 1*5+2*6+3*7+4*8 = 70
        beat(1, 1, 1, pk(1, 2, 3, 4), pk(5, 6, 7, 8));
        idle(5);

        // Three beats (10, -25, 7) with bubbles carrying junk flags -> -8
        beat(1, 1, 0, pk(10, 0, 0, 0), pk(1, 0, 0, 0));
        beat(0, 1, 1, pk(99, 99, 99, 99), pk(3, 3, 3, 3));
        beat(0, 1, 1, pk(-7, 5, 2, 1), pk(9, 9, 9, 9));
        beat(1, 0, 0, pk(-5, 0, 0, 0), pk(5, 0, 0, 0));
        beat(1, 0, 1, pk(7, 0, 0, 0), pk(1, 0, 0, 0));
        idle(5);

        // Back-to-back single-beat points
        for (int i = 0; i < 8; i++)
            beat(1, 1, 1, {$urandom(), $urandom()}, {$urandom(), $urandom()});
        idle(5);

        // Saturation, both directions
        beat(1, 1, 1, pk(32767, 32767, 32767, 32767), pk(32767, 32767, 32767, 32767));
        beat(1, 1, 1, pk(-32768, -32768, -32768, -32768), pk(32767, 32767, 32767, 32767));
        idle(5);

        // Shift rounding toward -inf: -17 and 17
        beat(1, 1, 1, pk(-17, 0, 0, 0), pk(1, 0, 0, 0));
        beat(1, 1, 1, pk(17, 0, 0, 0), pk(1, 0, 0, 0));
        idle(5);

        // Stale accumulator (100 then 5 without first -> 105)
        beat(1, 1, 1, pk(100, 0, 0, 0), pk(1, 0, 0, 0));
        beat(1, 0, 1, pk(5, 0, 0, 0), pk(1, 0, 0, 0));
        // Mid-point first discards the partial 1000 -> 20 + 3
        beat(1, 1, 0, pk(1000, 0, 0, 0), pk(1, 0, 0, 0));
        beat(1, 1, 0, pk(20, 0, 0, 0), pk(1, 0, 0, 0));
        beat(1, 0, 1, pk(3, 0, 0, 0), pk(1, 0, 0, 0));
        idle(5);

        // Reset mid-point; a valid first+last beat during reset is ignored
        beat(1, 1, 0, pk(11, 0, 0, 0), pk(1, 0, 0, 0));
        beat(1, 0, 0, pk(22, 0, 0, 0), pk(1, 0, 0, 0));
        rst = 1'b1;
        set_in(1'b1, 1'b1, 1'b1, pk(50, 0, 0, 0), pk(1, 0, 0, 0));
        @(posedge clk); #1;
        rst  = 1'b0;
        macc = 0;
        chk_zero("post_reset");
        idle(5);
        // Accumulator starts from zero after reset, then a fresh point
        beat(1, 0, 1, pk(9, 0, 0, 0), pk(1, 0, 0, 0));
        beat(1, 1, 0, pk(4, 0, 0, 0), pk(1, 0, 0, 0));
        beat(1, 0, 1, pk(6, 0, 0, 0), pk(1, 0, 0, 0));
        idle(5);

        // Random beats, flags and bubbles
        for (int i = 0; i < 40; i++)
            beat($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 2) == 0,
                 {$urandom(), $urandom()}, {$urandom(), $urandom()});
        idle(6);

        chk("d0_pending", longint'(q0.size()), 0);
        chk("d1_pending", longint'(q1.size()), 0);
        chk("d2_pending", longint'(q2.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
